// File: rtl/vecaris_arb_pkg.sv
// vecaris_arb_pkg
//   Shared definitions for the VECARIS memory-port arbiter:
//   - arb_state_e : FSM encoding (IDLE, GRANT, BUSY)
//   - SEL_REQ0..2 : select codes driven to the 3-to-1 address/data mux
//   - NUM_REQ     : number of requesters (fixed by the mux width)
//   - rr_next     : modulo-3 increment of a requester index
package vecaris_arb_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;

  // Next requester index in round-robin order; 2 wraps to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == SEL_REQ2) ? SEL_REQ0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational rotate-priority search over three requesters.
//   Candidates are tried in the order last+1, last+2, last+3 (mod 3), so the
//   requester served most recently has the lowest priority.
// Ports:
//   req   in  [2:0] request vector, bit i = requester i
//   last  in  [1:0] index of the most recently served requester (0..2)
//   idx   out [1:0] chosen requester (SEL_REQ0 when nothing is requested)
//   valid out       at least one request is present
module rr_pick
  import vecaris_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       valid
);

  logic [1:0] cand;

  always_comb begin
    idx   = SEL_REQ0;
    valid = 1'b0;
    cand  = rr_next(last);
    for (int k = 0; k < 3; k++) begin
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter and transfer sequencer for the shared 16-bit memory
//   port. One requester owns the port per transfer; the block drives the
//   select of the existing 3-to-1 address/data mux, strobes memory and
//   reports completion to the owner.
//
//   Handshake: a requester raises req[i] and holds it until it sees done[i]
//   (a one-cycle pulse). The block samples req only in IDLE; a grant, once
//   made, is carried to completion regardless of later req changes. Memory
//   sees mem_en high for the whole BUSY phase and answers with a one-cycle
//   mem_ack, which is ignored outside BUSY.
//
//   Optional feature (macro ARB_TIMEOUT_EN): a BUSY watchdog that aborts the
//   transfer after TIMEOUT cycles without mem_ack and pulses err. Without the
//   macro BUSY waits indefinitely and err is tied low.
//
// Ports:
//   clk      in        rising-edge clock
//   rst_n    in        asynchronous active-low reset
//   req      in  [2:0] request per requester
//   mem_ack  in        memory completed the current access (pulse)
//   sel      out [1:0] mux select, 00/01/10 = requester 0/1/2
//   grant    out [2:0] one-hot current owner, zero when idle
//   mem_en   out       access strobe, high throughout BUSY
//   done     out [2:0] one-cycle completion pulse to the owner
//   busy     out       high in GRANT or BUSY
//   err      out       one-cycle timeout pulse
module mem_port_arbiter
  import vecaris_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mem_ack,
  output logic [1:0]         sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               mem_en,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               err
);

  arb_state_e         state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               mem_en_q, mem_en_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [1:0]         last_q, last_d;

  logic [1:0]         pick_idx;
  logic               pick_valid;

  rr_pick u_rr_pick (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  // The counter holds (BUSY cycles elapsed - 1), so the abort fires at the
  // end of BUSY cycle number TIMEOUT.
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    mem_en_d = 1'b0;
    done_d   = '0;
    busy_d   = busy_q;
    last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // sel keeps its previous value while nothing is granted.
        if (pick_valid) begin
          sel_d           = pick_idx;
          grant_d         = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d          = 1'b1;
          state_d         = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // Settle cycle: mux outputs stabilise before memory is strobed.
        mem_en_d = 1'b1;
        state_d  = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = 4'd0;
`endif
      end

      ST_BUSY: begin
        mem_en_d = 1'b1;
        if (mem_ack) begin
          done_d   = grant_q;
          last_d   = sel_q;
          grant_d  = '0;
          mem_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // An ack in the limit cycle takes the branch above and wins.
        else if (cnt_q == TIMEOUT_LAST) begin
          err_d    = 1'b1;
          last_d   = sel_q;
          grant_d  = '0;
          mem_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_REQ0;
      grant_q  <= '0;
      mem_en_q <= 1'b0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      last_q   <= SEL_REQ2;  // requester 0 gets first priority
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      mem_en_q <= mem_en_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign sel    = sel_q;
  assign grant  = grant_q;
  assign mem_en = mem_en_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A transaction-level reference
//   model (round-robin pick from the last served requester, fixed phase
//   timing) predicts owner, select, completion and grant spacing.
//   Timeout scenarios are exercised when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       mem_ack = 1'b0;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       mem_en;
  logic [2:0] done;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;
  int last_m = 2;
  int cyc = 0;

  mem_port_arbiter #(.NUM_REQ(3), .TIMEOUT(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mem_ack (mem_ack),
    .sel     (sel),
    .grant   (grant),
    .mem_en  (mem_en),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference model: first requester found searching last+1, last+2, last+3.
  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int i);
    logic [2:0] v;
    v = 3'b000;
    if (i >= 0 && i < 3) v[i] = 1'b1;
    return v;
  endfunction

  // Drivers (all driving and sampling on the falling edge)
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    req = 3'b000;
    mem_ack = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    last_m = 2;
  endtask

  // Waits up to 20 cycles for a grant to appear; ticks = cycles waited.
  task automatic wait_grant(output int ticks);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      ticks++;
      if (grant !== 3'b000) break;
    end
  endtask

  // Called in the GRANT cycle. Memory acks so that mem_en stays high for
  // lat cycles; raise is OR-ed into req on the first BUSY cycle.
  task automatic do_xfer(input int lat, input logic [2:0] raise,
                         output logic [2:0] d, output int en_cnt,
                         output logic en_after, output logic err_at_done);
    d = 3'b000;
    en_cnt = 0;
    en_after = 1'bx;
    err_at_done = 1'bx;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (mem_en === 1'b1) begin
        if (en_cnt == 0) req = req | raise;
        en_cnt++;
      end
      if (en_cnt == lat) begin
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        d = done;
        en_after = mem_en;
        err_at_done = err;
        break;
      end
    end
  endtask

  // Scenarios
  task automatic test_reset;
    rst_n = 1'b0;
    req = 3'b111;
    mem_ack = 1'b1;
    tick;
    tick;
    checks++;
    if ({sel, grant, mem_en, done, busy, err} !== 11'b0) begin
      failures++;
      $display("FAIL reset_values: got sel=%b grant=%b mem_en=%b done=%b busy=%b err=%b, want all zero",
               sel, grant, mem_en, done, busy, err);
    end
    mem_ack = 1'b0;
    req = 3'b000;
    rst_n = 1'b1;
    last_m = 2;
    tick;
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got grant=%b busy=%b, want 000/0", grant, busy);
    end
  endtask

  task automatic test_single;
    int t, en;
    logic [2:0] d;
    logic ea, ed;
    req = 3'b010;
    wait_grant(t);
    checks++;
    if (grant !== 3'b010 || sel !== 2'b01 || busy !== 1'b1 || mem_en !== 1'b0 || t != 1) begin
      failures++;
      $display("FAIL single_grant: got grant=%b sel=%b busy=%b mem_en=%b wait=%0d, want 010/01/1/0/1",
               grant, sel, busy, mem_en, t);
    end
    do_xfer(2, 3'b000, d, en, ea, ed);
    req = 3'b000;
    checks++;
    if (d !== 3'b010 || en != 2 || ea !== 1'b0 || busy !== 1'b0 || grant !== 3'b000) begin
      failures++;
      $display("FAIL single_done: got done=%b en_cycles=%0d mem_en=%b busy=%b grant=%b, want 010/2/0/0/000",
               d, en, ea, busy, grant);
    end
    last_m = 1;
    tick;
    checks++;
    if (done !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: got done=%b busy=%b, want 000/0", done, busy);
    end
  endtask

  // Memory answers one cycle after it sees mem_en: 2 BUSY cycles, 4-cycle period.
  task automatic test_rotation;
    int t, en, prev_cyc, exp;
    logic [2:0] d;
    logic ea, ed;
    apply_reset;
    req = 3'b111;
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      exp = pick(3'b111, last_m);
      wait_grant(t);
      checks++;
      if (grant !== onehot(exp) || sel !== 2'(exp)) begin
        failures++;
        $display("FAIL rotation_grant[%0d]: got grant=%b sel=%b, want %b/%0d", i, grant, sel, onehot(exp), exp);
      end
      if (i > 0) begin
        checks++;
        if (cyc - prev_cyc != 4) begin
          failures++;
          $display("FAIL rotation_period[%0d]: got %0d cycles, want 4", i, cyc - prev_cyc);
        end
      end
      prev_cyc = cyc;
      do_xfer(2, 3'b000, d, en, ea, ed);
      checks++;
      if (d !== onehot(exp)) begin
        failures++;
        $display("FAIL rotation_done[%0d]: got %b, want %b", i, d, onehot(exp));
      end
      last_m = exp;
    end
    req = 3'b000;
    tick;
  endtask

  task automatic test_late_arrival;
    int t, en, exp;
    logic [2:0] d;
    logic ea, ed;
    req = 3'b001;
    exp = pick(req, last_m);
    wait_grant(t);
    checks++;
    if (grant !== onehot(exp)) begin
      failures++;
      $display("FAIL late_first_grant: got %b, want %b", grant, onehot(exp));
    end
    do_xfer(3, 3'b100, d, en, ea, ed);
    checks++;
    if (d !== 3'b001 || en != 3) begin
      failures++;
      $display("FAIL late_first_done: got done=%b en_cycles=%0d, want 001/3", d, en);
    end
    last_m = exp;
    req = req & ~3'b001;
    exp = pick(req, last_m);
    wait_grant(t);
    checks++;
    if (grant !== 3'b100 || sel !== 2'b10 || t != 1 || exp != 2) begin
      failures++;
      $display("FAIL late_second_grant: got grant=%b sel=%b wait=%0d, want 100/10/1", grant, sel, t);
    end
    do_xfer(1, 3'b000, d, en, ea, ed);
    req = 3'b000;
    last_m = 2;
    checks++;
    if (d !== 3'b100) begin
      failures++;
      $display("FAIL late_second_done: got %b, want 100", d);
    end
  endtask

  task automatic test_owner_drop;
    int t, en, pulses;
    logic [2:0] d;
    logic ea, ed;
    req = 3'b010;
    wait_grant(t);
    req = 3'b000;
    do_xfer(3, 3'b000, d, en, ea, ed);
    last_m = 1;
    pulses = (d === 3'b010) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (done !== 3'b000) pulses++;
      if (grant !== 3'b000) pulses += 10;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL owner_drop: got done=%b pulse_score=%0d, want one done 010 and no regrant", d, pulses);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    int t, en;
    logic [2:0] d;
    logic ea, ed;
    logic saw_done;
    apply_reset;
    req = 3'b001;
    wait_grant(t);
    en = 0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done !== 3'b000) saw_done = 1'b1;
      if (err === 1'b1) break;
      if (mem_en === 1'b1) en++;
    end
    checks++;
    if (err !== 1'b1 || en != 15 || saw_done || grant !== 3'b000 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL timeout_abort: got err=%b busy_cycles=%0d done_seen=%b grant=%b mem_en=%b, want 1/15/0/000/0",
               err, en, saw_done, grant, mem_en);
    end
    last_m = 0;
    req = 3'b010;
    wait_grant(t);
    checks++;
    if (grant !== 3'b010 || t != 1 || err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_next_grant: got grant=%b wait=%0d err=%b, want 010/1/0", grant, t, err);
    end
    do_xfer(15, 3'b000, d, en, ea, ed);
    req = 3'b000;
    last_m = 1;
    checks++;
    if (d !== 3'b010 || ed !== 1'b0 || en != 15) begin
      failures++;
      $display("FAIL timeout_ack_at_limit: got done=%b err=%b en_cycles=%0d, want 010/0/15", d, ed, en);
    end
  endtask
`else
  task automatic test_no_timeout;
    int t;
    logic stuck_ok;
    apply_reset;
    req = 3'b001;
    wait_grant(t);
    tick;
    stuck_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (mem_en !== 1'b1 || err !== 1'b0 || done !== 3'b000) stuck_ok = 1'b0;
      tick;
    end
    checks++;
    if (!stuck_ok) begin
      failures++;
      $display("FAIL wait_without_ack: got mem_en=%b err=%b done=%b, want 1/0/000 for 20 cycles", mem_en, err, done);
    end
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (done !== 3'b001 || err !== 1'b0) begin
      failures++;
      $display("FAIL late_ack_done: got done=%b err=%b, want 001/0", done, err);
    end
    req = 3'b000;
    last_m = 0;
  endtask
`endif

  task automatic test_mid_reset;
    int t, en;
    logic [2:0] d;
    logic ea, ed;
    req = 3'b010;
    wait_grant(t);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, grant, mem_en, done, busy, err} !== 11'b0) begin
      failures++;
      $display("FAIL mid_reset_values: got sel=%b grant=%b mem_en=%b done=%b busy=%b err=%b, want all zero",
               sel, grant, mem_en, done, busy, err);
    end
    req = 3'b000;
    tick;
    tick;
    rst_n = 1'b1;
    last_m = 2;
    req = 3'b101;
    wait_grant(t);
    checks++;
    if (grant !== 3'b001 || sel !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_grant: got grant=%b sel=%b, want 001/00", grant, sel);
    end
    do_xfer(1, 3'b000, d, en, ea, ed);
    req = 3'b000;
    last_m = 0;
    checks++;
    if (d !== 3'b001) begin
      failures++;
      $display("FAIL post_reset_done: got %b, want 001", d);
    end
    tick;
  endtask

  // Random requesters (each holds its request until served) and random
  // memory latency, checked against the round-robin model.
  task automatic test_random;
    logic [2:0] pend, d;
    int exp, t, en, lat;
    logic ea, ed;
    logic [2:0] exp_q[$];
    apply_reset;
    pend = 3'($urandom_range(1, 7));
    req = pend;
    for (int n = 0; n < 30; n++) begin
      exp = pick(pend, last_m);
      exp_q.push_back(onehot(exp));
      wait_grant(t);
      checks++;
      if (grant !== onehot(exp) || sel !== 2'(exp) || busy !== 1'b1 || t != 1) begin
        failures++;
        $display("FAIL random_grant[%0d]: got grant=%b sel=%b busy=%b wait=%0d, want %b/%0d/1/1",
                 n, grant, sel, busy, t, onehot(exp), exp);
      end
      lat = $urandom_range(1, 4);
      do_xfer(lat, 3'($urandom_range(0, 7)) & ~pend, d, en, ea, ed);
      checks++;
      if (d !== exp_q.pop_front() || en != lat || ea !== 1'b0 || ed !== 1'b0) begin
        failures++;
        $display("FAIL random_done[%0d]: got done=%b en_cycles=%0d mem_en=%b err=%b, want %b/%0d/0/0",
                 n, d, en, ea, ed, onehot(exp), lat);
      end
      last_m = exp;
      pend = (req & ~onehot(exp)) | 3'($urandom_range(0, 7));
      if (pend == 3'b000) pend = 3'($urandom_range(1, 7));
      req = pend;
    end
    req = 3'b000;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_late_arrival;
    test_owner_drop;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    test_mid_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
